cdc_fifo_word_assembler: RTL and testbench

//  Read-side consumer of the 4-bit CDC FIFO: pops nibbles from the FIFO read port, packs BEATS

---
 rtl/cdc_fifo_pkg.sv | 26 ++
 rtl/cdc_fifo_word_assembler.sv | 100 ++++++++++
 tb/tb_cdc_fifo_word_assembler.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_fifo_pkg.sv
// Shared constants for the 4-bit CDC FIFO and its read-side consumers.
//   CDC_DATA_WIDTH    : width of one FIFO entry (nibble)
//   CDC_ADDRESS_WIDTH : FIFO address width, shared with the FIFO top
//   clog2 / beat_idx_width : width helpers for the word assembler
package cdc_fifo_pkg;

    localparam int CDC_DATA_WIDTH    = 4;
    localparam int CDC_ADDRESS_WIDTH = 5;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // A beat index always needs at least one bit, even when clog2 would give 0.
    function automatic int beat_idx_width(input int beats);
        int w;
        w = clog2(beats);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/cdc_fifo_word_assembler.sv
// Read-side consumer of the CDC FIFO. Pops BEATS consecutive entries (first
// popped = least significant) and presents them as one word on a registered
// valid/ready output slot. Lives in the read clock domain.
//
// Ports:
//   clk          read-domain clock
//   rst_n        asynchronous active-low reset
//   fifo_empty   FIFO empty flag
//   fifo_data    FIFO head entry, valid whenever fifo_empty=0
//   fifo_pop     FIFO read increment; head is consumed on the clk edge
//   flush        synchronous discard of a partially assembled word
//   word_data    assembled word
//   word_valid   word_data holds an undelivered word
//   word_ready   downstream accepts word_data this cycle
//   partial      1..BEATS-1 beats held in the shift register
//   word_count   delivered-word counter, wraps
//
// State       | meaning
// ------------+------------------------------------------------------
// ASSEMBLE_k  | beat_idx = k: beats 0..k-1 of the next word are held
// slot EMPTY  | word_valid = 0: output register free
// slot FULL   | word_valid = 1: word waiting for word_ready
//
// BEATS legal range is 2..8.
module cdc_fifo_word_assembler
    import cdc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = CDC_DATA_WIDTH,
    parameter int BEATS       = 2,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        fifo_empty,
    input  logic [DATA_WIDTH-1:0]       fifo_data,
    output logic                        fifo_pop,
    input  logic                        flush,
    output logic [DATA_WIDTH*BEATS-1:0] word_data,
    output logic                        word_valid,
    input  logic                        word_ready,
    output logic                        partial,
    output logic [COUNT_WIDTH-1:0]      word_count
);

    localparam int BIW     = beat_idx_width(BEATS);
    localparam int SHIFT_W = (BEATS - 1) * DATA_WIDTH;
    localparam logic [BIW-1:0] LAST_BEAT = BIW'(BEATS - 1);

    logic [BIW-1:0]     beat_idx;
    logic [SHIFT_W-1:0] shift;
    logic               last_beat;
    logic               deliver;
    logic               pop;

    assign last_beat = (beat_idx == LAST_BEAT);
    assign deliver   = word_valid && word_ready;

    // Only the final beat depends on the output slot: it may pop when the slot
    // is free or is being emptied this same edge. rst_n gating keeps the FIFO
    // untouched while reset is held.
    assign pop      = rst_n && !fifo_empty && !flush &&
                      (!last_beat || !word_valid || word_ready);
    assign fifo_pop = pop;
    assign partial  = (beat_idx != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_idx   <= '0;
            shift      <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
            word_count <= '0;
        end else begin
            if (deliver) begin
                word_count <= word_count + COUNT_WIDTH'(1);
                word_valid <= 1'b0;
            end

            if (flush) begin
                beat_idx <= '0;
                shift    <= '0;
            end else if (pop) begin
                if (last_beat) begin
                    // A load on the same edge as a delivery overrides the clear above.
                    word_data  <= {fifo_data, shift};
                    word_valid <= 1'b1;
                    beat_idx   <= '0;
                end else begin
                    for (int i = 0; i < BEATS - 1; i++) begin
                        if (beat_idx == BIW'(i)) begin
                            shift[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_data;
                        end
                    end
                    beat_idx <= beat_idx + BIW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cdc_fifo_word_assembler.sv
module tb_cdc_fifo_word_assembler;

    logic       clk;
    logic       rst_n;
    logic       fifo_empty;
    logic [3:0] fifo_data;
    logic       fifo_pop;
    logic       flush;
    logic [7:0] word_data;
    logic       word_valid;
    logic       word_ready;
    logic       partial;
    logic [7:0] word_count;

    int checks = 0;
    int errors = 0;

    logic [3:0] q[$];
    logic [3:0] tx[$];
    logic [7:0] rx[$];
    logic       gap_gate = 1'b0;
    int         pop_cnt = 0;
    logic [7:0] exp_count = 8'd0;

    cdc_fifo_word_assembler #(
        .DATA_WIDTH (4),
        .BEATS      (2),
        .COUNT_WIDTH(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_pop  (fifo_pop),
        .flush     (flush),
        .word_data (word_data),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .partial   (partial),
        .word_count(word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_inputs();
        fifo_empty = gap_gate || (q.size() == 0);
        fifo_data  = (q.size() != 0) ? q[0] : 4'h0;
    endtask

    // Starts at (or shortly after) a negedge, ends at the next negedge.
    task automatic cycle();
        logic did_pop;
        logic dv;
        logic [7:0] d;
        apply_inputs();
        #3;
        checks++;
        if (fifo_pop && fifo_empty) begin
            errors++;
            $display("FAIL underflow: fifo_pop=%0b while fifo_empty=%0b at %0t", fifo_pop, fifo_empty, $time);
        end
        did_pop = fifo_pop;
        dv      = word_valid && word_ready;
        d       = word_data;
        @(posedge clk);
        if (did_pop) begin
            void'(q.pop_front());
            pop_cnt++;
        end
        if (dv) rx.push_back(d);
        @(negedge clk);
        apply_inputs();
    endtask

    task automatic check_word(input string name, input logic [7:0] exp_data, input logic exp_valid);
        checks++;
        if (word_valid !== exp_valid || (exp_valid && word_data !== exp_data)) begin
            errors++;
            $display("FAIL %s: word_valid=%0b word_data=%h, expected valid=%0b data=%h",
                     name, word_valid, word_data, exp_valid, exp_data);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; flush = 1'b0; word_ready = 1'b0;
        q.push_back(4'hF);
        apply_inputs();
        #1 rst_n = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (word_valid !== 1'b0 || word_data !== 8'h00 || word_count !== 8'h00 ||
            partial !== 1'b0 || fifo_pop !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%0b data=%h count=%0d partial=%0b pop=%0b, expected all 0",
                     word_valid, word_data, word_count, partial, fifo_pop);
        end
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        q.push_back(4'hC);
        word_ready = 1'b1;
        cycle();
        checks++;
        if (partial !== 1'b1) begin
            errors++;
            $display("FAIL reset_partial_before: partial=%0b, expected 1", partial);
        end
        q.push_back(4'hD);
        apply_inputs();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (partial !== 1'b0 || fifo_pop !== 1'b0 || word_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: partial=%0b pop=%0b valid=%0b, expected 0 0 0",
                     partial, fifo_pop, word_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        q.push_back(4'hE);
        cycle(); cycle();
        check_word("reset_restart_word", 8'hED, 1'b1);
        cycle();
        exp_count = exp_count + 8'd1;
        checks++;
        if (rx.size() == 0 || rx[rx.size()-1] !== 8'hED || word_count !== exp_count) begin
            errors++;
            $display("FAIL reset_restart_deliver: rx_n=%0d count=%0d, expected last ED count=%0d",
                     rx.size(), word_count, exp_count);
        end
    endtask

    task automatic test_basic();
        word_ready = 1'b1;
        q.push_back(4'h3); q.push_back(4'hA);
        pop_cnt = 0;
        cycle();
        check_word("basic_after_beat0", 8'h00, 1'b0);
        cycle();
        check_word("basic_word", 8'hA3, 1'b1);
        cycle();
        exp_count = exp_count + 8'd1;
        checks++;
        if (word_valid !== 1'b0 || word_count !== exp_count || pop_cnt != 2) begin
            errors++;
            $display("FAIL basic_deliver: valid=%0b count=%0d pops=%0d, expected 0 %0d 2",
                     word_valid, word_count, pop_cnt, exp_count);
        end
    endtask

    task automatic test_stall();
        word_ready = 1'b0;
        q.push_back(4'h1); q.push_back(4'h2); q.push_back(4'h3); q.push_back(4'h4);
        pop_cnt = 0;
        cycle(); cycle();
        check_word("stall_first_word", 8'h21, 1'b1);
        cycle(); cycle(); cycle();
        check_word("stall_held_word", 8'h21, 1'b1);
        checks++;
        if (pop_cnt != 3 || q.size() != 1 || fifo_pop !== 1'b0 || partial !== 1'b1) begin
            errors++;
            $display("FAIL stall_pops: pops=%0d left=%0d pop=%0b partial=%0b, expected 3 1 0 1",
                     pop_cnt, q.size(), fifo_pop, partial);
        end
        word_ready = 1'b1;
        #1;
        checks++;
        if (fifo_pop !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_pop: fifo_pop=%0b, expected 1", fifo_pop);
        end
        cycle();
        exp_count = exp_count + 8'd1;
        check_word("stall_back_to_back", 8'h43, 1'b1);
        checks++;
        if (word_count !== exp_count) begin
            errors++;
            $display("FAIL stall_count1: count=%0d, expected %0d", word_count, exp_count);
        end
        cycle();
        exp_count = exp_count + 8'd1;
        checks++;
        if (word_valid !== 1'b0 || word_count !== exp_count ||
            rx[rx.size()-2] !== 8'h21 || rx[rx.size()-1] !== 8'h43) begin
            errors++;
            $display("FAIL stall_deliver: valid=%0b count=%0d, expected 0 %0d with 21,43 delivered",
                     word_valid, word_count, exp_count);
        end
    endtask

    task automatic test_empty_gaps();
        word_ready = 1'b1;
        q.push_back(4'h5); q.push_back(4'h6);
        gap_gate = 1'b0;
        for (int i = 0; i < 6; i++) begin
            gap_gate = ~gap_gate;
            cycle();
        end
        gap_gate = 1'b0;
        apply_inputs();
        exp_count = exp_count + 8'd1;
        checks++;
        if (rx[rx.size()-1] !== 8'h65 || q.size() != 0 || word_count !== exp_count) begin
            errors++;
            $display("FAIL gaps_word: last=%h left=%0d count=%0d, expected 65 0 %0d",
                     rx[rx.size()-1], q.size(), word_count, exp_count);
        end
    endtask

    task automatic test_flush();
        word_ready = 1'b1;
        q.push_back(4'h7);
        cycle();
        checks++;
        if (partial !== 1'b1) begin
            errors++;
            $display("FAIL flush_partial_before: partial=%0b, expected 1", partial);
        end
        flush = 1'b1;
        q.push_back(4'h8);
        apply_inputs();
        #1;
        checks++;
        if (fifo_pop !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_pop: fifo_pop=%0b, expected 0", fifo_pop);
        end
        cycle();
        flush = 1'b0;
        checks++;
        if (partial !== 1'b0 || q.size() != 1) begin
            errors++;
            $display("FAIL flush_cleared: partial=%0b left=%0d, expected 0 1", partial, q.size());
        end
        q.push_back(4'h9);
        cycle(); cycle();
        check_word("flush_word", 8'h98, 1'b1);
        cycle();
        exp_count = exp_count + 8'd1;
        checks++;
        if (word_count !== exp_count || rx[rx.size()-1] !== 8'h98) begin
            errors++;
            $display("FAIL flush_deliver: count=%0d last=%h, expected %0d 98",
                     word_count, rx[rx.size()-1], exp_count);
        end
    endtask

    task automatic test_count_wrap();
        int n;
        int target;
        logic [7:0] exp_word;
        target = 256 - int'(exp_count);
        rx.delete();
        tx.delete();
        for (int i = 0; i < 2 * target + 20; i++) begin
            tx.push_back(4'($urandom_range(0, 15)));
            q.push_back(tx[i]);
        end
        n = 0;
        while (rx.size() < target && n < 6000) begin
            word_ready = ($urandom_range(0, 2) != 0);
            gap_gate   = ($urandom_range(0, 3) == 0);
            cycle();
            n++;
        end
        gap_gate = 1'b0;
        checks++;
        if (rx.size() < target) begin
            errors++;
            $display("FAIL wrap_timeout: delivered=%0d, expected %0d", rx.size(), target);
        end else begin
            checks++;
            if (word_count !== 8'd0) begin
                errors++;
                $display("FAIL wrap_count: count=%0d, expected 0", word_count);
            end
            for (int i = 0; i < target; i++) begin
                exp_word = {tx[2*i+1], tx[2*i]};
                checks++;
                if (rx[i] !== exp_word) begin
                    errors++;
                    $display("FAIL wrap_word[%0d]: got=%h, expected %h", i, rx[i], exp_word);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_empty_gaps();
        test_flush();
        test_count_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
